cosim_commit_queue: RTL and testbench

//  Multi-hart retirement-trace buffer for Spike lock-step co-simulation.
//  - Captures one commit record per hart per cycle into a per-hart FIFO.
//  - Drains all FIFOs round-robin through one registered valid/ready port
//    to the checker. The checker calls step()/get_spike_commit_info()
//    per record.
//  - Successor to the single-hart direct DPI compare: it adds parametrised

---
 rtl/cosim_commit_queue.sv | 216 +++++++++++++++++++++
 tb/tb_cosim_commit_queue.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cosim_commit_queue.sv
// Multi-hart retirement-trace buffer: per-hart commit FIFOs drained round-robin
// through one registered valid/ready port. Define COSIM_COMMIT_TIMESTAMP_EN to add out_cycle_o.
module cosim_commit_queue #(
  parameter int NUM_HARTS = 4,
  parameter int DEPTH     = 8,
  parameter int XLEN      = 64,
  parameter int CAUSE_W   = 6,
  parameter int SEQ_W     = 16,
  localparam int HART_W   = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic [NUM_HARTS-1:0]         commit_valid_i,
  output logic [NUM_HARTS-1:0]         commit_ready_o,
  input  logic [NUM_HARTS*XLEN-1:0]    commit_pc_i,
  input  logic [NUM_HARTS*32-1:0]      commit_ins_i,
  input  logic [NUM_HARTS*5-1:0]       commit_dst_i,
  input  logic [NUM_HARTS-1:0]         commit_wr_valid_i,
  input  logic [NUM_HARTS*XLEN-1:0]    commit_data_i,
  input  logic [NUM_HARTS-1:0]         commit_xcpt_i,
  input  logic [NUM_HARTS*CAUSE_W-1:0] commit_cause_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [HART_W-1:0]            out_hart_o,
  output logic [SEQ_W-1:0]             out_seq_o,
  output logic [XLEN-1:0]              out_pc_o,
  output logic [31:0]                  out_ins_o,
  output logic [4:0]                   out_dst_o,
  output logic                         out_wr_valid_o,
  output logic [XLEN-1:0]              out_data_o,
  output logic                         out_xcpt_o,
  output logic [CAUSE_W-1:0]           out_cause_o,
  output logic [NUM_HARTS-1:0]         overflow_o
`ifdef COSIM_COMMIT_TIMESTAMP_EN
  , output logic [63:0]                out_cycle_o
`endif
);

  typedef struct packed {
`ifdef COSIM_COMMIT_TIMESTAMP_EN
    logic [63:0]        cycle;
`endif
    logic [SEQ_W-1:0]   seq;
    logic [XLEN-1:0]    pc;
    logic [31:0]        ins;
    logic [4:0]         dst;
    logic               wr_valid;
    logic [XLEN-1:0]    data;
    logic               xcpt;
    logic [CAUSE_W-1:0] cause;
  } rec_t;

  typedef enum logic {S_EMPTY, S_FULL} state_e;

  state_e               state_q, state_d;
  rec_t                 mem_q [NUM_HARTS][DEPTH];
  rec_t                 rec_in [NUM_HARTS];
  rec_t                 out_rec_q, out_rec_d;
  logic [AW:0]          wptr_q [NUM_HARTS];
  logic [AW:0]          wptr_d [NUM_HARTS];
  logic [AW:0]          rptr_q [NUM_HARTS];
  logic [AW:0]          rptr_d [NUM_HARTS];
  logic [SEQ_W-1:0]     seq_q [NUM_HARTS];
  logic [SEQ_W-1:0]     seq_d [NUM_HARTS];
  logic [NUM_HARTS-1:0] ovf_q, ovf_d;
  logic [HART_W-1:0]    rr_q, rr_d, out_hart_q, out_hart_d;
  logic [HART_W-1:0]    grant, cand;
  logic [NUM_HARTS-1:0] empty, full, pop, push;
  logic                 found, load;
  int                   idx;
`ifdef COSIM_COMMIT_TIMESTAMP_EN
  logic [63:0]          cycle_q, cycle_d;
`endif

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    for (int h = 0; h < NUM_HARTS; h++) begin
      empty[h] = (wptr_q[h] == rptr_q[h]);
      full[h]  = (wptr_q[h][AW] != rptr_q[h][AW]) &&
                 (wptr_q[h][AW-1:0] == rptr_q[h][AW-1:0]);
      rec_in[h]          = '0;
      rec_in[h].seq      = seq_q[h];
      rec_in[h].pc       = commit_pc_i[h*XLEN +: XLEN];
      rec_in[h].ins      = commit_ins_i[h*32 +: 32];
      rec_in[h].dst      = commit_dst_i[h*5 +: 5];
      rec_in[h].wr_valid = commit_wr_valid_i[h];
      rec_in[h].data     = commit_data_i[h*XLEN +: XLEN];
      rec_in[h].xcpt     = commit_xcpt_i[h];
      rec_in[h].cause    = commit_cause_i[h*CAUSE_W +: CAUSE_W];
`ifdef COSIM_COMMIT_TIMESTAMP_EN
      rec_in[h].cycle    = cycle_q;
`endif
    end
  end

  // Scan from the farthest offset down so the first non-empty hart at or after rr_q wins.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    cand  = '0;
    for (int i = NUM_HARTS - 1; i >= 0; i--) begin
      idx = int'(rr_q) + i;
      if (idx >= NUM_HARTS) idx = idx - NUM_HARTS;
      cand = HART_W'(idx);
      if (!empty[cand]) begin
        found = 1'b1;
        grant = cand;
      end
    end
  end

  always_comb begin
    load       = (state_q == S_EMPTY) || out_ready_i;
    pop        = '0;
    state_d    = state_q;
    rr_d       = rr_q;
    out_rec_d  = out_rec_q;
    out_hart_d = out_hart_q;
    ovf_d      = ovf_q;
    if (load && found) pop[grant] = 1'b1;
    if (load) begin
      if (found) begin
        state_d    = S_FULL;
        out_rec_d  = mem_q[grant][rptr_q[grant][AW-1:0]];
        out_hart_d = grant;
        rr_d       = (int'(grant) == NUM_HARTS - 1) ? '0 : grant + 1'b1;
      end else begin
        state_d = S_EMPTY;
      end
    end
    for (int h = 0; h < NUM_HARTS; h++) begin
      commit_ready_o[h] = !full[h] || pop[h];
      push[h]   = commit_valid_i[h] && (!full[h] || pop[h]) && !flush_i;
      wptr_d[h] = wptr_q[h] + {{AW{1'b0}}, push[h]};
      rptr_d[h] = rptr_q[h] + {{AW{1'b0}}, pop[h]};
      seq_d[h]  = seq_q[h] + {{(SEQ_W-1){1'b0}}, commit_valid_i[h]};
      if (commit_valid_i[h] && full[h] && !pop[h]) ovf_d[h] = 1'b1;
    end
`ifdef COSIM_COMMIT_TIMESTAMP_EN
    cycle_d = cycle_q + 64'd1;
`endif
    // Flush wins over everything computed above, including this cycle's commits.
    if (flush_i) begin
      state_d    = S_EMPTY;
      rr_d       = '0;
      out_rec_d  = '0;
      out_hart_d = '0;
      ovf_d      = '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        wptr_d[h] = '0;
        rptr_d[h] = '0;
        seq_d[h]  = '0;
      end
`ifdef COSIM_COMMIT_TIMESTAMP_EN
      cycle_d = '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_EMPTY;
      rr_q       <= '0;
      out_rec_q  <= '0;
      out_hart_q <= '0;
      ovf_q      <= '0;
      for (int h = 0; h < NUM_HARTS; h++) begin
        wptr_q[h] <= '0;
        rptr_q[h] <= '0;
        seq_q[h]  <= '0;
      end
`ifdef COSIM_COMMIT_TIMESTAMP_EN
      cycle_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      out_rec_q  <= out_rec_d;
      out_hart_q <= out_hart_d;
      ovf_q      <= ovf_d;
      for (int h = 0; h < NUM_HARTS; h++) begin
        wptr_q[h] <= wptr_d[h];
        rptr_q[h] <= rptr_d[h];
        seq_q[h]  <= seq_d[h];
      end
`ifdef COSIM_COMMIT_TIMESTAMP_EN
      cycle_q <= cycle_d;
`endif
    end
  end

  // Storage is not reset; entries are only visible between valid pointers.
  always_ff @(posedge clk) begin
    for (int h = 0; h < NUM_HARTS; h++)
      if (push[h]) mem_q[h][wptr_q[h][AW-1:0]] <= rec_in[h];
  end

  assign out_valid_o    = (state_q == S_FULL);
  assign out_hart_o     = out_hart_q;
  assign out_seq_o      = out_rec_q.seq;
  assign out_pc_o       = out_rec_q.pc;
  assign out_ins_o      = out_rec_q.ins;
  assign out_dst_o      = out_rec_q.dst;
  assign out_wr_valid_o = out_rec_q.wr_valid;
  assign out_data_o     = out_rec_q.data;
  assign out_xcpt_o     = out_rec_q.xcpt;
  assign out_cause_o    = out_rec_q.cause;
  assign overflow_o     = ovf_q;
`ifdef COSIM_COMMIT_TIMESTAMP_EN
  assign out_cycle_o    = out_rec_q.cycle;
`endif

endmodule

// File: tb/tb_cosim_commit_queue.sv
// Directed bench for cosim_commit_queue: default 4-hart instance plus a small
// 2-hart/DEPTH=2/SEQ_W=4 instance for sequence wrap.
module tb_cosim_commit_queue;

  logic clk = 1'b0;
  logic rst, flush;
  always #5 clk = ~clk;

  // Default instance
  logic [3:0]   cv, cwr, cx, cready, ovf;
  logic [255:0] cpc, cdata;
  logic [127:0] cins;
  logic [19:0]  cdst;
  logic [23:0]  ccause;
  logic         ordy, out_valid, out_wr, out_x;
  logic [1:0]   out_hart;
  logic [15:0]  out_seq;
  logic [63:0]  out_pc, out_data;
  logic [31:0]  out_ins;
  logic [4:0]   out_dst;
  logic [5:0]   out_cause;
`ifdef COSIM_COMMIT_TIMESTAMP_EN
  logic [63:0]  out_cycle, d2_cycle;
`endif

  // Small instance
  logic [1:0]  d2_cv, d2_wr, d2_x, d2_cready, d2_ovf;
  logic [63:0] d2_pc, d2_ins, d2_data;
  logic [9:0]  d2_dst;
  logic [11:0] d2_cause;
  logic        d2_ordy, d2_valid, d2_wr_o, d2_x_o;
  logic [0:0]  d2_hart;
  logic [3:0]  d2_seq;
  logic [31:0] d2_pc_o, d2_ins_o, d2_data_o;
  logic [4:0]  d2_dst_o;
  logic [5:0]  d2_cause_o;

  cosim_commit_queue dut (
    .clk(clk), .rst(rst), .flush_i(flush),
    .commit_valid_i(cv), .commit_ready_o(cready),
    .commit_pc_i(cpc), .commit_ins_i(cins), .commit_dst_i(cdst),
    .commit_wr_valid_i(cwr), .commit_data_i(cdata),
    .commit_xcpt_i(cx), .commit_cause_i(ccause),
    .out_valid_o(out_valid), .out_ready_i(ordy), .out_hart_o(out_hart),
    .out_seq_o(out_seq), .out_pc_o(out_pc), .out_ins_o(out_ins),
    .out_dst_o(out_dst), .out_wr_valid_o(out_wr), .out_data_o(out_data),
    .out_xcpt_o(out_x), .out_cause_o(out_cause), .overflow_o(ovf)
`ifdef COSIM_COMMIT_TIMESTAMP_EN
    , .out_cycle_o(out_cycle)
`endif
  );

  cosim_commit_queue #(.NUM_HARTS(2), .DEPTH(2), .XLEN(32), .CAUSE_W(6), .SEQ_W(4)) dut2 (
    .clk(clk), .rst(rst), .flush_i(flush),
    .commit_valid_i(d2_cv), .commit_ready_o(d2_cready),
    .commit_pc_i(d2_pc), .commit_ins_i(d2_ins), .commit_dst_i(d2_dst),
    .commit_wr_valid_i(d2_wr), .commit_data_i(d2_data),
    .commit_xcpt_i(d2_x), .commit_cause_i(d2_cause),
    .out_valid_o(d2_valid), .out_ready_i(d2_ordy), .out_hart_o(d2_hart),
    .out_seq_o(d2_seq), .out_pc_o(d2_pc_o), .out_ins_o(d2_ins_o),
    .out_dst_o(d2_dst_o), .out_wr_valid_o(d2_wr_o), .out_data_o(d2_data_o),
    .out_xcpt_o(d2_x_o), .out_cause_o(d2_cause_o), .overflow_o(d2_ovf)
`ifdef COSIM_COMMIT_TIMESTAMP_EN
    , .out_cycle_o(d2_cycle)
`endif
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_commit(input int h, input logic [63:0] pc, input logic x, input logic [5:0] cause);
    cv[h]             = 1'b1;
    cpc[h*64 +: 64]   = pc;
    cins[h*32 +: 32]  = 32'h13 + 32'(h);
    cdst[h*5 +: 5]    = 5'(h + 1);
    cwr[h]            = 1'b1;
    cdata[h*64 +: 64] = pc ^ 64'hFFFF;
    cx[h]             = x;
    ccause[h*6 +: 6]  = cause;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ordy = 1'b0;
    cv = '0; cwr = '0; cx = '0; cpc = '0; cdata = '0; cins = '0; cdst = '0; ccause = '0;
    d2_cv = '0; d2_wr = '0; d2_x = '0; d2_pc = '0; d2_ins = '0; d2_data = '0;
    d2_dst = '0; d2_cause = '0; d2_ordy = 1'b0;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ready", cready, 4'hF);
    chk("rst_pc", out_pc, 0);
    chk("rst_seq", out_seq, 0);
    chk("rst_hart", out_hart, 0);
    chk("rst_d2_valid", d2_valid, 0);
    chk("rst_d2_ready", d2_cready, 2'b11);
    tick();
    rst = 1'b0;

    // All four harts commit for 8 cycles; output rotates 0,1,2,3 one per cycle.
    ordy = 1'b1;
    for (int c = 0; c < 34; c++) begin
      cv = '0;
      if (c < 8)
        for (int h = 0; h < 4; h++) set_commit(h, 64'(h * 256 + c), 1'b0, 6'd0);
      if (c >= 2) begin
        chk("t2_valid", out_valid, 1);
        chk("t2_hart", out_hart, (c - 2) % 4);
        chk("t2_seq", out_seq, (c - 2) / 4);
        chk("t2_pc", out_pc, ((c - 2) % 4) * 256 + (c - 2) / 4);
      end else begin
        chk("t2_valid_early", out_valid, 0);
      end
      tick();
    end
    cv = '0;
    chk("t2_idle", out_valid, 0);
    chk("t2_ovf", ovf, 0);

    // Single commit on hart 2: visible two cycles later, gone after the handshake.
    do_reset();
    ordy = 1'b1;
    set_commit(2, 64'h8000_0000, 1'b1, 6'd13);
    chk("t1_v_n", out_valid, 0);
    tick();
    cv = '0;
    chk("t1_v_n1", out_valid, 0);
    tick();
    chk("t1_valid", out_valid, 1);
    chk("t1_hart", out_hart, 2);
    chk("t1_seq", out_seq, 0);
    chk("t1_pc", out_pc, 64'h8000_0000);
    chk("t1_ins", out_ins, 32'h15);
    chk("t1_dst", out_dst, 3);
    chk("t1_wr", out_wr, 1);
    chk("t1_data", out_data, 64'h8000_FFFF);
    chk("t1_xcpt", out_x, 1);
    chk("t1_cause", out_cause, 13);
    tick();
    chk("t1_after", out_valid, 0);

    // Async reset while a record is held and another is queued.
    ordy = 1'b0;
    set_commit(0, 64'h40, 1'b0, 6'd0);
    set_commit(1, 64'h44, 1'b0, 6'd0);
    tick();
    cv = '0;
    tick();
    chk("ar_held", out_valid, 1);
    chk("ar_pc", out_pc, 64'h40);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_pc0", out_pc, 0);
    chk("ar_ready", cready, 4'hF);
    tick();
    rst = 1'b0;
    ordy = 1'b1;
    tick();
    chk("ar_no_partial", out_valid, 0);

    // Overflow: ten commits on hart 0 with the checker stalled.
    do_reset();
    ordy = 1'b0;
    for (int c = 0; c < 10; c++) begin
      cv = '0;
      set_commit(0, 64'h100 + 64'(c), 1'b0, 6'd0);
      chk("t3_ready", cready[0], (c < 9));
      chk("t3_ovf_pre", ovf, 0);
      tick();
    end
    cv = '0;
    chk("t3_ovf", ovf, 4'b0001);
    chk("t3_valid", out_valid, 1);
    chk("t3_seq0", out_seq, 0);
    chk("t3_full", cready[0], 0);
    ordy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk("t3_dvalid", out_valid, 1);
      chk("t3_dseq", out_seq, i);
      chk("t3_dpc", out_pc, 64'h100 + 64'(i));
      tick();
    end
    chk("t3_drained", out_valid, 0);
    chk("t3_sticky", ovf, 4'b0001);
    set_commit(0, 64'h1AA, 1'b0, 6'd0);
    tick();
    cv = '0;
    tick();
    chk("t3_gap_valid", out_valid, 1);
    chk("t3_gap_seq", out_seq, 10);
    chk("t3_gap_pc", out_pc, 64'h1AA);
    tick();

    // Push and pop on a full FIFO in the same cycle: no drop.
    do_reset();
    ordy = 1'b0;
    for (int c = 0; c < 9; c++) begin
      cv = '0;
      set_commit(0, 64'h200 + 64'(c), 1'b0, 6'd0);
      tick();
    end
    cv = '0;
    #1;
    chk("t4_full", cready[0], 0);
    set_commit(0, 64'h209, 1'b0, 6'd0);
    ordy = 1'b1;
    #1;
    chk("t4_ready_comb", cready[0], 1);
    tick();
    cv = '0;
    ordy = 1'b0;
    #1;
    chk("t4_ovf", ovf, 0);
    chk("t4_seq1", out_seq, 1);
    chk("t4_still_full", cready[0], 0);
    ordy = 1'b1;
    for (int i = 1; i < 10; i++) begin
      chk("t4_dseq", out_seq, i);
      chk("t4_dpc", out_pc, 64'h200 + 64'(i));
      tick();
    end
    chk("t4_drained", out_valid, 0);

    // Sequence wrap on the 4-bit instance: ... 0xF then 0x0.
    d2_ordy = 1'b1;
    for (int c = 0; c < 19; c++) begin
      d2_cv = '0;
      if (c < 17) begin
        d2_cv[1]       = 1'b1;
        d2_pc[32 +: 32] = 32'h1000 + 32'(c);
      end
      if (c >= 2) begin
        chk("t5_valid", d2_valid, 1);
        chk("t5_hart", d2_hart, 1);
        chk("t5_seq", d2_seq, (c - 2) & 15);
        chk("t5_pc", d2_pc_o, 32'h1000 + 32'(c - 2));
      end
      tick();
    end
    d2_cv = '0;
    chk("t5_idle", d2_valid, 0);
    chk("t5_ovf", d2_ovf, 0);

    // Flush with records queued, an overflow flagged, and commits in flight.
    ordy = 1'b0;
    for (int c = 0; c < 11; c++) begin
      cv = '0;
      set_commit(1, 64'h500 + 64'(c), 1'b0, 6'd0);
      tick();
    end
    cv = '0;
    chk("t6_ovf_set", ovf, 4'b0010);
    flush = 1'b1;
    ordy = 1'b1;
    set_commit(1, 64'h5FF, 1'b0, 6'd0);
    set_commit(2, 64'h6FF, 1'b0, 6'd0);
    tick();
    flush = 1'b0;
    cv = '0;
    chk("t6_valid", out_valid, 0);
    chk("t6_ovf", ovf, 0);
    chk("t6_ready", cready, 4'hF);
    chk("t6_pc", out_pc, 0);
    set_commit(1, 64'h600, 1'b0, 6'd0);
    set_commit(2, 64'h700, 1'b0, 6'd0);
    tick();
    cv = '0;
    tick();
    chk("t6_h1_valid", out_valid, 1);
    chk("t6_h1_hart", out_hart, 1);
    chk("t6_h1_seq", out_seq, 0);
    chk("t6_h1_pc", out_pc, 64'h600);
`ifdef COSIM_COMMIT_TIMESTAMP_EN
    chk("t6_cycle", out_cycle, 64'd0);
`endif
    tick();
    chk("t6_h2_hart", out_hart, 2);
    chk("t6_h2_seq", out_seq, 0);
    chk("t6_h2_pc", out_pc, 64'h700);
    tick();
    chk("t6_idle", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
